// File: rtl/conv_fmap_collector.sv
`default_nettype none
// conv_fmap_collector - captures conv-array output columns into an OUT_SIZE x OUT_SIZE
// buffer and streams the finished map row-major over valid/ready.  Rev 1.0
module conv_fmap_collector #(
   parameter  int DATA_WIDTH = 32,
   parameter  int OUT_SIZE   = 24,
   parameter  int RELU_EN    = 0,
   localparam int IW         = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  col_valid,
   input  logic [DATA_WIDTH-1:0] col_data [OUT_SIZE],
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [IW-1:0]         m_row,
   output logic [IW-1:0]         m_col,
   output logic                  m_last,
   output logic                  done,
   output logic                  overflow
);

   localparam logic [IW-1:0] LAST_IDX = IW'(OUT_SIZE - 1);
   localparam logic [IW-1:0] ONE_IDX  = IW'(1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DRAIN   = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t                state_q;
   logic [IW-1:0]         wcol_q;
   logic [IW-1:0]         rrow_q;
   logic [IW-1:0]         rcol_q;
   logic [IW-1:0]         rrow_d;
   logic [IW-1:0]         rcol_d;
   logic                  m_valid_q;
   logic                  m_last_q;
   logic                  done_q;
   logic                  overflow_q;
   logic [DATA_WIDTH-1:0] m_data_q;
   logic [DATA_WIDTH-1:0] entry_data_d;
   logic [DATA_WIDTH-1:0] col_f    [OUT_SIZE];
   logic [DATA_WIDTH-1:0] mem_q    [OUT_SIZE][OUT_SIZE];

   function automatic logic [DATA_WIDTH-1:0] relu_f(input logic [DATA_WIDTH-1:0] x);
      return ((RELU_EN != 0) && x[DATA_WIDTH-1]) ? '0 : x;
   endfunction

   always_comb begin
      for (int i = 0; i < OUT_SIZE; i++) begin
         col_f[i] = relu_f(col_data[i]);
      end
   end

   // Row-major successor of the current read position.
   always_comb begin
      rrow_d = rrow_q;
      rcol_d = rcol_q;
      if (rcol_q == LAST_IDX) begin
         rcol_d = '0;
         rrow_d = rrow_q + ONE_IDX;
      end else begin
         rcol_d = rcol_q + ONE_IDX;
      end
   end

   // A 1x1 map has its only element arriving in the same cycle DRAIN is entered.
   assign entry_data_d = (OUT_SIZE == 1) ? col_f[0] : mem_q[0][0];

   always_ff @(posedge clk) begin
      if ((state_q == S_COLLECT) && col_valid) begin
         for (int i = 0; i < OUT_SIZE; i++) begin
            mem_q[i][wcol_q] <= col_f[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         wcol_q     <= '0;
         rrow_q     <= '0;
         rcol_q     <= '0;
         m_valid_q  <= 1'b0;
         m_data_q   <= '0;
         m_last_q   <= 1'b0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  wcol_q     <= '0;
                  rrow_q     <= '0;
                  rcol_q     <= '0;
                  overflow_q <= col_valid;
                  state_q    <= S_COLLECT;
               end else if (col_valid) begin
                  overflow_q <= 1'b1;
               end
            end
            S_COLLECT: begin
               if (col_valid) begin
                  if (wcol_q == LAST_IDX) begin
                     state_q   <= S_DRAIN;
                     m_valid_q <= 1'b1;
                     m_data_q  <= entry_data_d;
                     m_last_q  <= (OUT_SIZE == 1);
                  end else begin
                     wcol_q <= wcol_q + ONE_IDX;
                  end
               end
            end
            S_DRAIN: begin
               if (col_valid) begin
                  overflow_q <= 1'b1;
               end
               if (m_ready) begin
                  if (m_last_q) begin
                     state_q   <= S_DONE;
                     m_valid_q <= 1'b0;
                     m_last_q  <= 1'b0;
                     m_data_q  <= '0;
                     rrow_q    <= '0;
                     rcol_q    <= '0;
                  end else begin
                     rrow_q   <= rrow_d;
                     rcol_q   <= rcol_d;
                     m_data_q <= mem_q[rrow_d][rcol_d];
                     m_last_q <= (rrow_d == LAST_IDX) && (rcol_d == LAST_IDX);
                  end
               end
            end
            S_DONE: begin
               if (col_valid) begin
                  overflow_q <= 1'b1;
               end
               done_q  <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign m_valid  = m_valid_q;
   assign m_data   = m_data_q;
   assign m_row    = rrow_q;
   assign m_col    = rcol_q;
   assign m_last   = m_last_q;
   assign done     = done_q;
   assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_fmap_collector.sv
`default_nettype none
// tb_conv_fmap_collector - randomized bench; a plain 2-D reference map predicts every
// streamed element for a pass-through and a ReLU instance driven in lockstep.
module tb_conv_fmap_collector;
   localparam int DW = 32;
   localparam int N  = 24;
   localparam int IW = $clog2(N);

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          start     = 1'b0;
   logic          col_valid = 1'b0;
   logic          m_ready   = 1'b0;
   logic [DW-1:0] col_data [N];

   logic          m_valid_a, m_last_a, done_a, ovf_a;
   logic [DW-1:0] m_data_a;
   logic [IW-1:0] m_row_a, m_col_a;
   logic          m_valid_b, m_last_b, done_b, ovf_b;
   logic [DW-1:0] m_data_b;
   logic [IW-1:0] m_row_b, m_col_b;

   logic [DW-1:0] exp_raw [N][N];
   logic          ovf_exp = 1'b0;
   int            errors  = 0;
   int            checks  = 0;

   always #5 clk = ~clk;

   conv_fmap_collector #(.DATA_WIDTH(DW), .OUT_SIZE(N), .RELU_EN(0)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .col_valid(col_valid), .col_data(col_data),
      .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a), .m_row(m_row_a),
      .m_col(m_col_a), .m_last(m_last_a), .done(done_a), .overflow(ovf_a)
   );

   conv_fmap_collector #(.DATA_WIDTH(DW), .OUT_SIZE(N), .RELU_EN(1)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .col_valid(col_valid), .col_data(col_data),
      .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b), .m_row(m_row_b),
      .m_col(m_col_b), .m_last(m_last_b), .done(done_b), .overflow(ovf_b)
   );

   function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
      return ($signed(x) < 0) ? '0 : x;
   endfunction

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check_val({tag, "_m_valid"}, m_valid_a, 0);
      check_val({tag, "_m_data"},  m_data_a,  0);
      check_val({tag, "_m_row"},   m_row_a,   0);
      check_val({tag, "_m_col"},   m_col_a,   0);
      check_val({tag, "_m_last"},  m_last_a,  0);
      check_val({tag, "_done"},    done_a,    0);
   endtask

   // mode 0: i*100+c, mode 1: random, mode 2: column 0 = -10, rest random.
   task automatic send_map(input int mode, input int gap, input bit collide, input int ncols);
      logic [DW-1:0] v;
      start = 1'b1;
      if (collide) begin
         col_valid = 1'b1;
         for (int i = 0; i < N; i++) col_data[i] = 32'hBAD0_0000 | DW'(i);
      end
      tick();
      start     = 1'b0;
      col_valid = 1'b0;
      check_val("ovf_after_start", ovf_a, 64'(collide));
      ovf_exp = collide;
      for (int c = 0; c < ncols; c++) begin
         for (int i = 0; i < N; i++) begin
            case (mode)
               0:       v = DW'(i * 100 + c);
               1:       v = $urandom;
               default: v = (c == 0) ? 32'hFFFF_FFF6 : $urandom;
            endcase
            col_data[i]   = v;
            exp_raw[i][c] = v;
         end
         if (c == N - 1) check_val("m_valid_pre", m_valid_a, 0);
         col_valid = 1'b1;
         tick();
         col_valid = 1'b0;
         if (c < ncols - 1) repeat (gap) tick();
      end
      if (ncols == N) check_val("m_valid_rise", m_valid_a, 1);
   endtask

   // rmode 0: ready high, 1: 1-0-0-1 pattern, 2: random.
   task automatic drain_map(input int rmode, input bit inject);
      int k   = 0;
      int cyc = 0;
      while (k < N * N && cyc < 8000) begin
         case (rmode)
            0:       m_ready = 1'b1;
            1:       m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
         if (inject && cyc == 37) begin
            col_valid = 1'b1;
            start     = 1'b1;
            for (int i = 0; i < N; i++) col_data[i] = 32'h0000_DEAD;
            ovf_exp = 1'b1;
         end
         check_val("m_valid",  m_valid_a, 1);
         check_val("m_data",   m_data_a,  exp_raw[k / N][k % N]);
         check_val("m_row",    m_row_a,   64'(k / N));
         check_val("m_col",    m_col_a,   64'(k % N));
         check_val("m_last",   m_last_a,  64'(k == N * N - 1));
         check_val("m_data_relu", m_data_b, relu(exp_raw[k / N][k % N]));
         if (m_ready) k++;
         tick();
         cyc++;
         col_valid = 1'b0;
         start     = 1'b0;
      end
      check_val("drain_count", k, N * N);
      m_ready = 1'b0;
      check_idle_outputs("after_drain");
      tick();
      cyc++;
      check_val("done_pulse", done_a, 1);
      check_val("done_pulse_relu", done_b, 1);
      if (rmode == 0) check_val("done_latency", cyc, N * N + 1);
      tick();
      check_val("done_clear", done_a, 0);
      check_val("overflow", ovf_a, 64'(ovf_exp));
      check_val("overflow_relu", ovf_b, 64'(ovf_exp));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < N; i++) col_data[i] = '0;
      rst_n = 1'b0;
      tick();
      tick();
      check_idle_outputs("reset");
      check_val("reset_overflow", ovf_a, 0);
      rst_n = 1'b1;
      tick();

      send_map(0, 0, 1'b0, N);
      drain_map(0, 1'b0);

      send_map(1, 0, 1'b0, N);
      drain_map(1, 1'b0);

      send_map(2, 0, 1'b0, N);
      drain_map(2, 1'b0);

      send_map(1, 0, 1'b0, N);
      drain_map(0, 1'b1);

      send_map(0, 3, 1'b0, N);
      drain_map(0, 1'b0);

      send_map(1, 0, 1'b0, 10);
      rst_n = 1'b0;
      #1;
      check_idle_outputs("mid_reset");
      check_val("mid_reset_overflow", ovf_a, 0);
      tick();
      rst_n = 1'b1;
      tick();
      col_valid = 1'b1;
      tick();
      col_valid = 1'b0;
      tick();
      check_val("no_start_valid", m_valid_a, 0);
      check_val("idle_overflow", ovf_a, 1);
      send_map(1, 0, 1'b0, N);
      drain_map(0, 1'b0);

      send_map(1, 2, 1'b1, N);
      drain_map(2, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
